regfile_2r1w: RTL and testbench
===============================

# regfile_2r1w

Parametrised register file for the datapath: N registers of DATA_WIDTH bits, one synchronous write port and two independent combinational read ports, so both ALU operands are read in a single cycle. Adds synchronous reset, per-register valid flags and optional same-cycle write-to-read forwarding. Sits between the writeback mux and the operand latches of the datapath.

## Interface
- DATA_WIDTH, 16, bits per register
- ADDR_WIDTH, 3, register index width; NUM_REGS = 2**ADDR_WIDTH
- BYPASS, 1, 1 = forward data_in to a read port reading the register being written this cycle; 0 = reads return stored value only

- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high
- data_in  input  DATA_WIDTH  write data
- writenum  input  ADDR_WIDTH  write index
- write  input  1  write enable
- readnum_a  input  ADDR_WIDTH  read index, port A
- readnum_b  input  ADDR_WIDTH  read index, port B
- data_out_a  output  DATA_WIDTH  read data, port A
- data_out_b  output  DATA_WIDTH  read data, port B
- valid_a  output  1  register at readnum_a has been written since reset
- valid_b  output  1  register at readnum_b has been written since reset

## Operation
- Storage: NUM_REGS x DATA_WIDTH registers R[i], plus NUM_REGS valid bits V[i].
- Write: on rising clk with reset=0 and write=1, R[writenum] <= data_in, V[writenum] <= 1. All other registers hold.
- write=0: no register or valid bit changes, regardless of data_in/writenum.
- Reset: on rising clk with reset=1, all R[i] <= 0, all V[i] <= 0. Reset has priority over a simultaneous write; the write is dropped.
- Read (each port independent, purely combinational from indices and state): data_out_x = R[readnum_x], valid_x = V[readnum_x].
- Forwarding (BYPASS=1 only): if write=1, reset=0 and readnum_x == writenum, then data_out_x = data_in and valid_x = 1 in the same cycle, before the edge.
- Forwarding is suppressed while reset=1: outputs show stored state.
- Both ports may address the same register; both return identical values.
- No width conversion: all data paths are exactly DATA_WIDTH; indices exactly ADDR_WIDTH, every index value is a legal register.

## Timing
- Write latency: 1 edge. Value visible on a non-forwarded read port immediately after the capturing edge.
- Read latency: 0 cycles (combinational) from readnum_x change; with BYPASS=1, also 0 cycles from data_in/write/writenum change.
- After reset edge: every data_out_x = 0, every valid_x = 0, until the first write edge.
- Power-up before first reset: contents undefined; benches must reset first.
- Reset asserted mid-sequence: next edge clears all state; writes issued on that edge are lost; writes resume on the first edge with reset=0.
- Back-to-back writes to the same index: last edge wins.

## Structure
- Package regfile_pkg: default DATA_WIDTH/ADDR_WIDTH constants and the reset value (all zeros) for R.
- Sub-module regfile_dec: parametrised ADDR_WIDTH -> one-hot NUM_REGS decoder, instantiated once for the write index gated by write; read selects are mux logic in the top.
- Read mux and forwarding compare are duplicated per port in the top module (generate over ports acceptable).

## Test plan
- Reset then read all indices on both ports -> data_out_a/b = 0, valid_a/b = 0 for every index 0..7.
- Write 16'h002A to R0 ... 16'h1000 to R7 (one per cycle), then read A=i, B=7-i -> each port returns its written value, valid=1; write=0 cycles with data_in=0 leave all values unchanged.
- BYPASS=1: hold R3=16'h9122, drive write=1, writenum=3, data_in=16'h01E3, readnum_a=3, readnum_b=2 before the edge -> data_out_a=16'h01E3 same cycle, data_out_b = stored R2; rebuild with BYPASS=0 -> data_out_a=16'h9122 until the edge, 16'h01E3 after.
- Reset and write on the same edge (writenum=5, data_in=16'h0004) -> after edge R5=0, valid for index 5 = 0.
- Reset pulse after all registers written -> all reads 0/valid 0 next cycle; first post-reset write to R6=16'h0038 -> only index 6 valid.
- Parameter sweep DATA_WIDTH=32, ADDR_WIDTH=4: write 32'hDEADBEEF to R15, read both ports at 15 -> 32'hDEADBEEF, R0 still 0.

Source files
------------

// File: rtl/regfile_pkg.sv
// Shared constants for the 2-read/1-write register file: default geometry
// and the value every register takes on reset.
package regfile_pkg;

  localparam int DEFAULT_DATA_WIDTH = 16;
  localparam int DEFAULT_ADDR_WIDTH = 3;
  localparam int NUM_READ_PORTS     = 2;
  localparam int MAX_DATA_WIDTH     = 64;

  localparam logic [MAX_DATA_WIDTH-1:0] REG_RESET_VALUE = '0;

  typedef enum logic {
    PORT_A = 1'b0,
    PORT_B = 1'b1
  } read_port_e;

endpackage

// File: rtl/regfile_dec.sv
// Binary-to-one-hot decoder with an enable.
// Selects the single register that the write port updates this cycle.
module regfile_dec #(
  parameter int ADDR_WIDTH = regfile_pkg::DEFAULT_ADDR_WIDTH,
  parameter int NUM_REGS   = 2 ** ADDR_WIDTH
) (
  input  logic [ADDR_WIDTH-1:0] addr_i,
  input  logic                  en_i,
  output logic [NUM_REGS-1:0]   onehot_o
);

  always_comb begin
    onehot_o = '0;
    if (en_i) begin
      onehot_o[addr_i] = 1'b1;
    end
  end

endmodule

// File: rtl/regfile_2r1w.sv
// Register file with one synchronous write port, two combinational read
// ports, per-register valid flags and optional write-to-read forwarding.
module regfile_2r1w
  import regfile_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter bit BYPASS     = 1'b1
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] data_in,
  input  logic [ADDR_WIDTH-1:0] writenum,
  input  logic                  write,
  input  logic [ADDR_WIDTH-1:0] readnum_a,
  input  logic [ADDR_WIDTH-1:0] readnum_b,
  output logic [DATA_WIDTH-1:0] data_out_a,
  output logic [DATA_WIDTH-1:0] data_out_b,
  output logic                  valid_a,
  output logic                  valid_b
);

  localparam int NUM_REGS = 2 ** ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] regData_q [NUM_REGS];
  logic [DATA_WIDTH-1:0] regData_d [NUM_REGS];
  logic [NUM_REGS-1:0]   regValid_q;
  logic [NUM_REGS-1:0]   regValid_d;
  logic [NUM_REGS-1:0]   writeSel;

  regfile_dec #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .NUM_REGS   (NUM_REGS)
  ) u_writeDec (
    .addr_i   (writenum),
    .en_i     (write),
    .onehot_o (writeSel)
  );

  always_comb begin
    regData_d  = regData_q;
    regValid_d = regValid_q;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (writeSel[i]) begin
        regData_d[i]  = data_in;
        regValid_d[i] = 1'b1;
      end
    end
  end

  // Reset wins over a same-edge write, so the write is simply discarded.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < NUM_REGS; i++) begin
        regData_q[i] <= REG_RESET_VALUE[DATA_WIDTH-1:0];
      end
      regValid_q <= '0;
    end else begin
      regData_q  <= regData_d;
      regValid_q <= regValid_d;
    end
  end

  logic fwdActive;
  assign fwdActive = BYPASS && write && !reset;

  for (genvar p = 0; p < NUM_READ_PORTS; p++) begin : gen_port
    logic [ADDR_WIDTH-1:0] rdIdx;
    logic [DATA_WIDTH-1:0] rdData;
    logic                  rdValid;

    assign rdIdx = (p == int'(PORT_A)) ? readnum_a : readnum_b;

    always_comb begin
      rdData  = regData_q[rdIdx];
      rdValid = regValid_q[rdIdx];
      if (fwdActive && (rdIdx == writenum)) begin
        rdData  = data_in;
        rdValid = 1'b1;
      end
    end
  end

  assign data_out_a = gen_port[0].rdData;
  assign valid_a    = gen_port[0].rdValid;
  assign data_out_b = gen_port[1].rdData;
  assign valid_b    = gen_port[1].rdValid;

endmodule

// File: tb/tb_regfile_2r1w.sv
// Randomised scoreboard bench for regfile_2r1w: a forwarding instance and a
// non-forwarding instance share stimulus; a 32x16 instance covers wide geometry.
module tb_regfile_2r1w;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] data_in;
  logic [2:0]  writenum;
  logic        write;
  logic [2:0]  readnum_a;
  logic [2:0]  readnum_b;
  logic [15:0] outA, outB, nbOutA, nbOutB;
  logic        validA, validB, nbValidA, nbValidB;

  logic        wReset;
  logic [31:0] wData;
  logic [3:0]  wWritenum;
  logic        wWrite;
  logic [3:0]  wReadA;
  logic [3:0]  wReadB;
  logic [31:0] wOutA, wOutB;
  logic        wValidA, wValidB;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(1'b1)) dut (
    .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(outA), .data_out_b(outB), .valid_a(validA), .valid_b(validB)
  );

  regfile_2r1w #(.DATA_WIDTH(16), .ADDR_WIDTH(3), .BYPASS(1'b0)) dutNb (
    .clk(clk), .reset(reset), .data_in(data_in), .writenum(writenum), .write(write),
    .readnum_a(readnum_a), .readnum_b(readnum_b),
    .data_out_a(nbOutA), .data_out_b(nbOutB), .valid_a(nbValidA), .valid_b(nbValidB)
  );

  regfile_2r1w #(.DATA_WIDTH(32), .ADDR_WIDTH(4), .BYPASS(1'b1)) dutWide (
    .clk(clk), .reset(wReset), .data_in(wData), .writenum(wWritenum), .write(wWrite),
    .readnum_a(wReadA), .readnum_b(wReadB),
    .data_out_a(wOutA), .data_out_b(wOutB), .valid_a(wValidA), .valid_b(wValidB)
  );

  typedef struct {
    logic [15:0] dA, dB, nA, nB;
    logic        vA, vB, nvA, nvB;
  } exp_t;

  typedef struct {
    logic [31:0] dA, dB;
    logic        vA, vB;
  } wexp_t;

  exp_t  expQ[$];
  wexp_t wExpQ[$];

  // Reference contents: what each register should hold after the last edge.
  logic [15:0] mR  [8];
  logic        mV  [8];
  logic [31:0] mRW [16];
  logic        mVW [16];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] expv);
    total++;
    if (act !== expv) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %h expected %h", name, $time, act, expv);
    end
  endtask

  task automatic applyStimulus(input logic rst, input logic wr, input logic [2:0] wn,
                               input logic [15:0] din, input logic [2:0] ra, input logic [2:0] rb);
    exp_t e;
    logic fwdA, fwdB;
    reset = rst; write = wr; writenum = wn; data_in = din;
    readnum_a = ra; readnum_b = rb;
    fwdA = wr && !rst && (ra == wn);
    fwdB = wr && !rst && (rb == wn);
    e.nA = mR[ra]; e.nvA = mV[ra];
    e.nB = mR[rb]; e.nvB = mV[rb];
    e.dA = fwdA ? din : mR[ra]; e.vA = fwdA ? 1'b1 : mV[ra];
    e.dB = fwdB ? din : mR[rb]; e.vB = fwdB ? 1'b1 : mV[rb];
    expQ.push_back(e);
    @(posedge clk);
    if (rst) begin
      for (int i = 0; i < 8; i++) begin mR[i] = '0; mV[i] = 1'b0; end
    end else if (wr) begin
      mR[wn] = din; mV[wn] = 1'b1;
    end
    #1;
  endtask

  task automatic applyWide(input logic wr, input logic [3:0] wn, input logic [31:0] din,
                           input logic [3:0] ra, input logic [3:0] rb);
    wexp_t e;
    wReset = 1'b0; wWrite = wr; wWritenum = wn; wData = din;
    wReadA = ra; wReadB = rb;
    e.dA = (wr && ra == wn) ? din : mRW[ra]; e.vA = (wr && ra == wn) ? 1'b1 : mVW[ra];
    e.dB = (wr && rb == wn) ? din : mRW[rb]; e.vB = (wr && rb == wn) ? 1'b1 : mVW[rb];
    wExpQ.push_back(e);
    @(posedge clk);
    if (wr) begin mRW[wn] = din; mVW[wn] = 1'b1; end
    #1;
  endtask

  always @(negedge clk) begin
    while (expQ.size() > 0) begin
      exp_t e;
      e = expQ.pop_front();
      checkOutput("bypass data_out_a", 32'(outA), 32'(e.dA));
      checkOutput("bypass data_out_b", 32'(outB), 32'(e.dB));
      checkOutput("bypass valid_a", 32'(validA), 32'(e.vA));
      checkOutput("bypass valid_b", 32'(validB), 32'(e.vB));
      checkOutput("nobypass data_out_a", 32'(nbOutA), 32'(e.nA));
      checkOutput("nobypass data_out_b", 32'(nbOutB), 32'(e.nB));
      checkOutput("nobypass valid_a", 32'(nbValidA), 32'(e.nvA));
      checkOutput("nobypass valid_b", 32'(nbValidB), 32'(e.nvB));
    end
    while (wExpQ.size() > 0) begin
      wexp_t w;
      w = wExpQ.pop_front();
      checkOutput("wide data_out_a", wOutA, w.dA);
      checkOutput("wide data_out_b", wOutB, w.dB);
      checkOutput("wide valid_a", 32'(wValidA), 32'(w.vA));
      checkOutput("wide valid_b", 32'(wValidB), 32'(w.vB));
    end
  end

  logic [15:0] initVals [8] = '{16'h002A, 16'h0101, 16'h0202, 16'h0404,
                                16'h0808, 16'h2020, 16'h4040, 16'h1000};

  initial begin
    reset = 1'b1; write = 1'b0; writenum = '0; data_in = '0;
    readnum_a = '0; readnum_b = '0;
    wReset = 1'b1; wWrite = 1'b0; wWritenum = '0; wData = '0; wReadA = '0; wReadB = '0;
    for (int i = 0; i < 8; i++) begin mR[i] = '0; mV[i] = 1'b0; end
    for (int i = 0; i < 16; i++) begin mRW[i] = '0; mVW[i] = 1'b0; end
    @(posedge clk);
    #1;
    wReset = 1'b0;

    $display("[TB] reset state on every index");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 3'(i), 16'hFFFF, 3'(i), 3'((i + 3) % 8));

    $display("[TB] fill all registers, then read back");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 3'(i), initVals[i], 3'(i), 3'((i + 7) % 8));
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 3'($urandom_range(0, 7)), 16'h0000, 3'(i), 3'(7 - i));
    for (int i = 0; i < 4; i++) applyStimulus(1'b0, 1'b0, 3'(i), 16'($urandom), 3'(i), 3'(i));

    $display("[TB] same-cycle forwarding on port A only");
    applyStimulus(1'b0, 1'b1, 3'd3, 16'h9122, 3'd0, 3'd1);
    applyStimulus(1'b0, 1'b1, 3'd3, 16'h01E3, 3'd3, 3'd2);
    applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 3'd3, 3'd3);

    $display("[TB] reset and write on the same edge");
    applyStimulus(1'b1, 1'b1, 3'd5, 16'h0004, 3'd5, 3'd5);
    applyStimulus(1'b0, 1'b0, 3'd5, 16'h0004, 3'd5, 3'd6);

    $display("[TB] reset pulse after full fill");
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b1, 3'(i), 16'($urandom), 3'(i), 3'(7 - i));
    applyStimulus(1'b1, 1'b0, 3'd0, 16'h0000, 3'd1, 3'd2);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));
    applyStimulus(1'b0, 1'b1, 3'd6, 16'h0038, 3'd0, 3'd1);
    for (int i = 0; i < 8; i++) applyStimulus(1'b0, 1'b0, 3'd0, 16'h0000, 3'(i), 3'(7 - i));

    $display("[TB] randomised traffic");
    for (int n = 0; n < 300; n++) begin
      logic [2:0] wn;
      wn = 3'($urandom_range(0, 7));
      applyStimulus(($urandom_range(0, 24) == 0), 1'($urandom_range(0, 1)), wn, 16'($urandom),
                    ($urandom_range(0, 2) == 0) ? wn : 3'($urandom_range(0, 7)),
                    ($urandom_range(0, 2) == 0) ? wn : 3'($urandom_range(0, 7)));
    end
    write = 1'b0; reset = 1'b0;

    $display("[TB] wide geometry");
    applyWide(1'b0, 4'd0, 32'h0, 4'd0, 4'd15);
    applyWide(1'b1, 4'd15, 32'hDEADBEEF, 4'd15, 4'd0);
    applyWide(1'b0, 4'd15, 32'h0, 4'd15, 4'd15);
    applyWide(1'b0, 4'd0, 32'h0, 4'd0, 4'd15);
    for (int n = 0; n < 40; n++) begin
      applyWide(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), $urandom,
                4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    end

    repeat (2) @(negedge clk);
    total++;
    if (expQ.size() != 0 || wExpQ.size() != 0) begin
      bad++;
      $display("[TB] FAIL scoreboard drain: got %0d pending expected 0", expQ.size() + wExpQ.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
